// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared seven-segment display types and constants.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int SEG_W  = 7;
    localparam int DIGITS = 8;

    typedef logic [3:0]       nibble_t;
    typedef logic [SEG_W-1:0] seg_t;

    // All segments off (active-low)
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Brief    : Nibble to active-low {g,f,e,d,c,b,a} hex glyph decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
    import disp_pkg::*;
(
    input  nibble_t i_nibble,
    output seg_t    o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/digit_bank_scan.sv
`default_nettype none
// ============================================================================
// Module   : digit_bank_scan
// Brief    : Captures demuxed nibbles into an 8-digit bank and scans them
//            onto a common-anode seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module digit_bank_scan
    import disp_pkg::*;
#(
    parameter  int REFRESH_DIV = 100000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] sel,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    input  logic [3:0] D4,
    input  logic [3:0] D5,
    input  logic [3:0] D6,
    input  logic [3:0] D7,
    input  logic [7:0] blank,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] scan_idx
);

    localparam seg_t       c_seg_zero = 7'b1000000;
    localparam logic [7:0] c_an_rst   = 8'b1111_1110;

    nibble_t          w_din [DIGITS];
    nibble_t          r_bank [DIGITS];
    logic [CNT_W-1:0] r_div;
    logic [2:0]       r_scan;
    logic [7:0]       r_an;
    seg_t             r_seg;

    nibble_t          w_cur;
    seg_t             w_seg;
    logic [7:0]       w_an;
    logic             w_div_wrap;

    assign w_din[0] = D0;
    assign w_din[1] = D1;
    assign w_din[2] = D2;
    assign w_din[3] = D3;
    assign w_din[4] = D4;
    assign w_din[5] = D5;
    assign w_din[6] = D6;
    assign w_din[7] = D7;

    assign w_div_wrap = (r_div == CNT_W'(REFRESH_DIV - 1));
    assign w_cur      = r_bank[r_scan];
    assign w_an       = blank[r_scan] ? 8'hFF : ~(8'b1 << r_scan);

    hex7seg u_dec (
        .i_nibble (w_cur),
        .o_seg    (w_seg)
    );

    // Outputs are registered from the pre-edge scan index and bank, so an
    // and seg always move together one cycle after the state they show.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_bank[i] <= '0;
            end
            r_div  <= '0;
            r_scan <= '0;
            r_an   <= c_an_rst;
            r_seg  <= c_seg_zero;
        end else begin
            if (we) begin
                r_bank[sel] <= w_din[sel];
            end
            if (w_div_wrap) begin
                r_div  <= '0;
                r_scan <= r_scan + 3'd1;
            end else begin
                r_div <= r_div + CNT_W'(1);
            end
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = 1'b1;
    assign scan_idx = r_scan;

endmodule
`default_nettype wire

// File: tb/tb_digit_bank_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_bank_scan
// Brief    : Scoreboard bench for digit_bank_scan with REFRESH_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_bank_scan;

    localparam int RDIV = 4;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic [2:0] scan;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [2:0] sel = '0;
    logic [3:0] dv [8];
    logic [7:0] blank = '0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] scan_idx;

    exp_t       q [$];
    logic [6:0] glyph [16];
    logic [3:0] sb [8];
    int         k = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    digit_bank_scan #(.REFRESH_DIV(RDIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .sel      (sel),
        .D0       (dv[0]),
        .D1       (dv[1]),
        .D2       (dv[2]),
        .D3       (dv[3]),
        .D4       (dv[4]),
        .D5       (dv[5]),
        .D6       (dv[6]),
        .D7       (dv[7]),
        .blank    (blank),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .scan_idx (scan_idx)
    );

    // Monitor: every expectation pushed before an edge is checked at the
    // following falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if (an !== e.an) begin
                errors++;
                $display("FAIL an t=%0t got %h want %h", $time, an, e.an);
            end
            if (seg !== e.seg) begin
                errors++;
                $display("FAIL seg t=%0t got %b want %b", $time, seg, e.seg);
            end
            if (scan_idx !== e.scan) begin
                errors++;
                $display("FAIL scan_idx t=%0t got %0d want %0d", $time, scan_idx, e.scan);
            end
            if (dp !== e.dp) begin
                errors++;
                $display("FAIL dp t=%0t got %b want %b", $time, dp, e.dp);
            end
        end
    end

    // One clock of stimulus; pushes what the outputs must read after the edge.
    task automatic step(input logic r, input logic w, input logic [2:0] s,
                        input logic [3:0] d, input logic [7:0] b);
        exp_t e;
        int   sp;
        @(negedge clk);
        #1;
        reset = r;
        we    = w;
        sel   = s;
        blank = b;
        for (int i = 0; i < 8; i++) dv[i] = (i == int'(s)) ? d : 4'h0;
        e.dp = 1'b1;
        if (r) begin
            e.an   = 8'hFE;
            e.seg  = 7'b1000000;
            e.scan = 3'd0;
            for (int i = 0; i < 8; i++) sb[i] = 4'h0;
            k = 0;
        end else begin
            sp     = (k / RDIV) % 8;
            e.an   = b[sp] ? 8'hFF : ~(8'b1 << sp);
            e.seg  = glyph[sb[sp]];
            if (w) sb[s] = d;
            k++;
            e.scan = 3'((k / RDIV) % 8);
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 4'h0, b);
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001;
        glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
        glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000;
        glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001;
        glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
        for (int i = 0; i < 8; i++) begin
            dv[i] = 4'h0;
            sb[i] = 4'h0;
        end

        // Reset for two cycles; the write during reset must be dropped
        step(1'b1, 1'b0, 3'd0, 4'h0, 8'h00);
        step(1'b1, 1'b1, 3'd3, 4'h7, 8'h00);
        idle(6, 8'h00);

        // Single write, then a full sweep to see it on digit 3 only
        step(1'b0, 1'b1, 3'd3, 4'hA, 8'h00);
        idle(34, 8'h00);

        // Load 1..8 into digits 0..7 and sweep past a wrap
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 4'(i + 1), 8'h00);
        idle(36, 8'h00);

        // Blank digit 2 for a full sweep
        idle(34, 8'b0000_0100);
        idle(2, 8'h00);

        // Live write to the digit being displayed
        while (!(((k / RDIV) % 8) == 5 && (k % RDIV) == 1)) idle(1, 8'h00);
        step(1'b0, 1'b1, 3'd5, 4'hF, 8'h00);
        idle(3, 8'h00);

        // Reset mid-scan with a loaded bank; coincident write is discarded
        while (((k / RDIV) % 8) != 6) idle(1, 8'h00);
        step(1'b1, 1'b1, 3'd6, 4'h9, 8'h00);
        idle(34, 8'h00);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/digit_bank_scan.md
Name: digit_bank_scan

Overview:
- Downstream consumer of the 4-bit, 8-way digit demultiplexer.
- Captures the demultiplexed nibbles into an 8-entry digit register bank.
- Time-multiplexes the stored digits onto an 8-digit common-anode seven-segment display.
- Sits between the digit-entry/demux logic and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (100 MHz gives 1 kHz per digit); legal range 2 and up.
- CNT_W, $clog2(REFRESH_DIV), width of the refresh divider counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write strobe for the digit bank.
- sel  input  3  index of the digit being written; the same select that drives the demux.
- D0..D7  input  4 each  demux outputs; only D[sel] carries data.
- blank  input  8  per-digit blank mask; bit i=1 turns digit i off.
- an  output  8  anode enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).
- scan_idx  output  3  index of the digit currently driven.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - bank[0..7] = 0, divider = 0, scan_idx = 0.
  - an = 8'b1111_1110.
  - seg = 7'b100_0000 (the glyph for 0).
  - dp = 1.
- Write path:
  - When we=1 at an edge, bank[sel] <= D[sel]; the demux zeros on the other outputs are ignored.
  - we=0 leaves the bank unchanged.
  - Only the selected entry changes; the other 7 hold.
- Divider:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and scan_idx increments.
  - scan_idx 7 wraps to 0.
- Output register stage: an and seg are registered and computed each cycle from the current scan_idx, bank and blank. Consequences:
  - A write at edge t appears on seg at edge t+1 if that digit is active.
  - A scan_idx change at edge t appears on an/seg at edge t+1 (one-cycle latency).
  - On the cycle an changes, seg changes on the same edge; there is no ghost cycle.
- an rules:
  - an = ~(8'b1 << scan_idx) when blank[scan_idx]=0.
  - an = 8'hFF when blank[scan_idx]=1; seg is don't-care while blanked but is still driven with the decoded value.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - A write plus a scan advance on the same edge: both take effect.
  - A write to the digit being displayed is shown on the next edge.
  - A write while reset=1 is discarded; reset wins.
- Reset mid-scan: the divider and scan_idx return to 0 on that edge and the bank is cleared.

Decomposition:
- Shared package disp_pkg:
  - SEG_W=7 and DIGITS=8 constants.
  - typedef nibble_t (logic [3:0]).
  - typedef seg_t (logic [6:0]).
  - localparam SEG_BLANK = 7'h7F.
- Sub-module hex7seg (combinational nibble_t to seg_t): reused by other labs.
- The top module holds the bank, divider, scan counter and output registers.

Test Plan (REFRESH_DIV=4):
- Reset: assert reset for 2 cycles, release -> an=FE, seg=1000000, scan_idx=0, dp=1. scan_idx becomes 1 four cycles after release and an=FD one cycle later.
- Write and display: we=1, sel=3, D3=4'hA -> after scan reaches 3, an=F7 and seg=0001000. Other digits still show 1000000.
- Full sweep:
  - Load digits 0..7 with 1,2,...,8.
  - Observe 32 cycles -> an walks FE,FD,FB,...,7F, then wraps to FE.
  - seg follows the table for each digit.
- Blank mask: blank=8'b0000_0100 -> while scan_idx=2, an=FF; all other digits display normally.
- Live write to the active digit: while scan_idx=5, write sel=5, D5=4'hF -> seg=0001110 on the next edge and an stays DF.
- Reset mid-operation: assert reset when scan_idx=6 with a nonzero bank -> next edge gives scan_idx=0 and an=FE. Every digit then reads 0 over a full sweep.
